// File: rtl/ssd_pkg.sv
// Shared widths, anode constants and scan types for the 7-segment scan multiplexer.
package ssd_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  typedef struct packed {
    logic [NIBBLE_W*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]          en;
    logic [MAX_DIGITS-1:0]          dp;
  } disp_t;

endpackage

// File: rtl/ssd_refresh_timer.sv
// Slot counter and BLANK/SHOW phase FSM; produces digit index and slot/frame strobes.
module ssd_refresh_timer
  import ssd_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000,
  parameter int unsigned NUM_DIGITS      = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] digit_idx,
  output logic [IDX_W-1:0] digit_idx_nxt,
  output logic             show_start,
  output logic             slot_wrap,
  output logic             frame_wrap
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_DIGIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_t      state_q, state_d;
  logic             last_tick;
  logic             blank_last;

  assign last_tick  = (cnt_q == CNT_W'(TICKS_PER_DIGIT - 1));
  assign blank_last = (cnt_q == CNT_W'(BLANK_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: if (blank_last) state_d = SHOW;
      SHOW:  if (last_tick)  state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    show_start = (state_q == BLANK) && blank_last;
    slot_wrap  = (state_q == SHOW) && last_tick;
    frame_wrap = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
  end

  always_comb begin
    cnt_d         = last_tick ? '0 : cnt_q + 1'b1;
    digit_idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    idx_d         = slot_wrap ? digit_idx_nxt : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign digit_idx = idx_q;

endmodule

// File: rtl/ssd_scan_mux.sv
// 8-digit hex scan multiplexer with frame-synchronous double buffering and anode blanking.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000,
  parameter int unsigned NUM_DIGITS      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NIBBLE_W*MAX_DIGITS-1:0] value_in,
  input  logic [MAX_DIGITS-1:0]          en_in,
  input  logic [MAX_DIGITS-1:0]          dp_in,
  output logic [NIBBLE_W-1:0]            digit_val,
  output logic                           dp_n,
  output logic [MAX_DIGITS-1:0]          an,
  output logic [IDX_W-1:0]               digit_idx,
  output logic                           frame_tick,
  output logic                           load_pending
);

  logic [IDX_W-1:0] idx_nxt;
  logic             show_start;
  logic             slot_wrap;
  logic             frame_wrap;

  ssd_refresh_timer #(
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT),
    .BLANK_TICKS    (BLANK_TICKS),
    .NUM_DIGITS     (NUM_DIGITS)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .digit_idx    (digit_idx),
    .digit_idx_nxt(idx_nxt),
    .show_start   (show_start),
    .slot_wrap    (slot_wrap),
    .frame_wrap   (frame_wrap)
  );

  disp_t                 shadow_q, shadow_d;
  disp_t                 active_q, active_d;
  logic                  load_pending_q, load_pending_d;
  logic [NIBBLE_W-1:0]   digit_val_q, digit_val_d;
  logic                  dp_n_q, dp_n_d;
  logic [MAX_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  always_comb begin
    shadow_d       = load ? {value_in, en_in, dp_in} : shadow_q;
    active_d       = (frame_wrap && load_pending_q) ? shadow_q : active_q;
    load_pending_d = load ? 1'b1 : (frame_wrap ? 1'b0 : load_pending_q);
    frame_tick_d   = frame_wrap;

    // Read through active_d so digit 0 sees data committed on this same edge.
    digit_val_d = digit_val_q;
    dp_n_d      = dp_n_q;
    if (slot_wrap) begin
      digit_val_d = active_d.value[{idx_nxt, 2'b00} +: NIBBLE_W];
      dp_n_d      = ~active_d.dp[idx_nxt];
    end

    an_d = an_q;
    if (slot_wrap) begin
      an_d = ANODE_OFF;
    end else if (show_start) begin
      an_d            = ANODE_OFF;
      an_d[digit_idx] = ~active_q.en[digit_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= '0;
      active_q       <= '0;
      load_pending_q <= 1'b0;
      digit_val_q    <= '0;
      dp_n_q         <= 1'b1;
      an_q           <= ANODE_OFF;
      frame_tick_q   <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      load_pending_q <= load_pending_d;
      digit_val_q    <= digit_val_d;
      dp_n_q         <= dp_n_d;
      an_q           <= an_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign digit_val    = digit_val_q;
  assign dp_n         = dp_n_q;
  assign an           = an_q;
  assign frame_tick   = frame_tick_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: an absolute-time display model predicts every cycle.
module tb_ssd_scan_mux;

  localparam int unsigned TPD   = 10;
  localparam int unsigned BT    = 2;
  localparam int unsigned ND    = 8;
  localparam int unsigned FRAME = TPD * ND;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] value_in;
  logic [7:0]  en_in;
  logic [7:0]  dp_in;
  logic [3:0]  digit_val;
  logic        dp_n;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;
  logic        load_pending;

  ssd_scan_mux #(
    .TICKS_PER_DIGIT(TPD),
    .BLANK_TICKS    (BT),
    .NUM_DIGITS     (ND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value_in    (value_in),
    .en_in       (en_in),
    .dp_in       (dp_in),
    .digit_val   (digit_val),
    .dp_n        (dp_n),
    .an          (an),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick),
    .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dv;
    logic       dpn;
    logic [7:0] an;
    logic [2:0] idx;
    logic       ft;
    logic       lp;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned t;
  logic [31:0] sh_v, ac_v;
  logic [7:0]  sh_e, ac_e, sh_d, ac_d;
  logic        pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // Reference model: position in the frame follows directly from edges since reset release.
  initial begin
    exp_t        e;
    int unsigned cnt, idx;
    t = 0; sh_v = '0; ac_v = '0; sh_e = '0; ac_e = '0; sh_d = '0; ac_d = '0; pend = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        t = 0; sh_v = '0; ac_v = '0; sh_e = '0; ac_e = '0; sh_d = '0; ac_d = '0; pend = 1'b0;
        sb_q.delete();
      end else begin
        t++;
        cnt  = t % TPD;
        idx  = (t / TPD) % ND;
        e.ft = (cnt == 0) && (idx == 0);
        if (e.ft && pend) begin
          ac_v = sh_v; ac_e = sh_e; ac_d = sh_d; pend = 1'b0;
        end
        if (load) begin
          sh_v = value_in; sh_e = en_in; sh_d = dp_in; pend = 1'b1;
        end
        e.idx = idx[2:0];
        e.dv  = ac_v[idx*4 +: 4];
        e.dpn = ~ac_d[idx];
        e.an  = (cnt >= BT && ac_e[idx]) ? ~(8'd1 << idx) : 8'hFF;
        e.lp  = pend;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("an", an, e.an);
        check_eq("digit_val", digit_val, e.dv);
        check_eq("dp_n", dp_n, e.dpn);
        check_eq("digit_idx", digit_idx, e.idx);
        check_eq("frame_tick", frame_tick, e.ft);
        check_eq("load_pending", load_pending, e.lp);
      end
    end
  end

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    value_in = v;
    en_in    = en;
    dp_in    = dp;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned pos);
    for (int i = 0; i < 200 && (t % FRAME) != pos; i++) @(negedge clk);
    check_eq("wait_frame_pos", t % FRAME, pos);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = '0; en_in = '0; dp_in = '0;
    #23;
    check_eq("rst_an", an, 8'hFF);
    check_eq("rst_digit_val", digit_val, 4'h0);
    check_eq("rst_dp_n", dp_n, 1'b1);
    check_eq("rst_digit_idx", digit_idx, 3'd0);
    check_eq("rst_frame_tick", frame_tick, 1'b0);
    check_eq("rst_load_pending", load_pending, 1'b0);
    @(negedge clk); #2 rst = 1'b0;

    // Dark display, frame ticks only
    repeat (200) @(negedge clk);

    // All digits lit, dp on digit 0
    do_load(32'h7654_3210, 8'hFF, 8'h01);
    repeat (170) @(negedge clk);

    // Only digits 1 and 3 enabled
    do_load(32'h89AB_CDEF, 8'h0A, 8'h00);
    repeat (170) @(negedge clk);

    // Two mid-frame loads: last one wins at the boundary
    wait_pos(30);
    do_load(32'hAAAA_AAAA, 8'hFF, 8'hF0);
    repeat (5) @(negedge clk);
    do_load(32'hBBBB_BBBB, 8'hFF, 8'h0F);
    repeat (170) @(negedge clk);

    // Load landing exactly on the commit edge
    wait_pos(20);
    do_load(32'h1111_1111, 8'hFF, 8'h00);
    wait_pos(FRAME - 1);
    do_load(32'h2222_2222, 8'hFF, 8'hFF);
    check_eq("boundary_load_pending", load_pending, 1'b1);
    check_eq("boundary_digit_val", digit_val, 4'h1);
    repeat (180) @(negedge clk);

    // Asynchronous reset while digit 1 is lit
    for (int i = 0; i < 100 && an !== 8'hFD; i++) @(negedge clk);
    check_eq("wait_an_fd", an, 8'hFD);
    #2 rst = 1'b1;
    #1;
    check_eq("async_an", an, 8'hFF);
    check_eq("async_digit_idx", digit_idx, 3'd0);
    check_eq("async_load_pending", load_pending, 1'b0);
    check_eq("async_dp_n", dp_n, 1'b1);
    @(negedge clk); #2 rst = 1'b0;
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
